// File: rtl/branch_resolve_ctrl.sv
// Branch resolution and misprediction recovery controller: trains the predictor,
// redirects the PC on a mispredict, holds a front-end flush, keeps statistics.
module branch_resolve_ctrl #(
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic              BRC_CLK,
   input  logic              BRC_RST_N,
   input  logic              BRC_EX_VALID,
   input  logic              BRC_EX_COND_BRN,
   input  logic              BRC_EX_PRED_TAKEN,
   input  logic              BRC_EX_TAKE,
   input  logic [ADDR_W-1:0] BRC_EX_ADDR,
   input  logic [ADDR_W-1:0] BRC_EX_TARGET,
   input  logic              BRC_STALL,
   input  logic              BRC_CNT_CLR,
   output logic              BRC_PC_LD,
   output logic [ADDR_W-1:0] BRC_PC_ADDR,
   output logic              BRC_FLUSH,
   output logic              BRC_UPD_VALID,
   output logic [ADDR_W-1:0] BRC_UPD_ADDR,
   output logic              BRC_UPD_TAKE,
   output logic              BRC_BUSY,
   output logic [CNT_W-1:0]  BRC_BRN_CNT,
   output logic [CNT_W-1:0]  BRC_MISP_CNT
);

   localparam int unsigned FC_W = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t              state, state_nxt;
   logic [FC_W-1:0]     fcnt, fcnt_nxt;
   logic                pc_ld, pc_ld_nxt;
   logic [ADDR_W-1:0]   pc_addr, pc_addr_nxt;
   logic                upd_valid, upd_valid_nxt;
   logic [ADDR_W-1:0]   upd_addr, upd_addr_nxt;
   logic                upd_take, upd_take_nxt;
   logic [CNT_W-1:0]    brn_cnt, brn_cnt_nxt;
   logic [CNT_W-1:0]    misp_cnt, misp_cnt_nxt;
   logic                eval_c;
   logic                misp_c;

   // Branches seen while flushing are wrong-path and never evaluated.
   assign eval_c = (state == IDLE) && !BRC_STALL && BRC_EX_VALID && BRC_EX_COND_BRN;
   assign misp_c = eval_c && (BRC_EX_PRED_TAKEN != BRC_EX_TAKE);

   // Next-state, recovery sequencing, predictor update and statistics.
   always_comb begin
      state_nxt     = state;
      fcnt_nxt      = fcnt;
      pc_ld_nxt     = 1'b0;
      pc_addr_nxt   = pc_addr;
      upd_valid_nxt = eval_c;
      upd_addr_nxt  = upd_addr;
      upd_take_nxt  = upd_take;
      brn_cnt_nxt   = brn_cnt;
      misp_cnt_nxt  = misp_cnt;

      if (eval_c) begin
         upd_addr_nxt = BRC_EX_ADDR;
         upd_take_nxt = BRC_EX_TAKE;
      end

      case (state)
         IDLE: begin
            if (misp_c) begin
               state_nxt   = FLUSH;
               fcnt_nxt    = FC_W'(FLUSH_CYCLES);
               pc_ld_nxt   = 1'b1;
               pc_addr_nxt = BRC_EX_TAKE ? BRC_EX_TARGET : (BRC_EX_ADDR + ADDR_W'(1));
            end
         end
         FLUSH: begin
            // The PC load survives stalled cycles and retires on the first free one.
            pc_ld_nxt = pc_ld && BRC_STALL;
            if (!BRC_STALL) begin
               if (fcnt <= FC_W'(1)) begin
                  state_nxt = IDLE;
                  fcnt_nxt  = '0;
               end else begin
                  fcnt_nxt  = fcnt - FC_W'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            fcnt_nxt  = '0;
         end
      endcase

      // Clear wins over a same-cycle increment; both counters saturate.
      if (BRC_CNT_CLR) begin
         brn_cnt_nxt  = '0;
         misp_cnt_nxt = '0;
      end else begin
         if (eval_c && (brn_cnt != {CNT_W{1'b1}}))
            brn_cnt_nxt = brn_cnt + CNT_W'(1);
         if (misp_c && (misp_cnt != {CNT_W{1'b1}}))
            misp_cnt_nxt = misp_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge BRC_CLK or negedge BRC_RST_N) begin
      if (!BRC_RST_N) begin
         state     <= IDLE;
         fcnt      <= '0;
         pc_ld     <= 1'b0;
         pc_addr   <= '0;
         upd_valid <= 1'b0;
         upd_addr  <= '0;
         upd_take  <= 1'b0;
         brn_cnt   <= '0;
         misp_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         fcnt      <= fcnt_nxt;
         pc_ld     <= pc_ld_nxt;
         pc_addr   <= pc_addr_nxt;
         upd_valid <= upd_valid_nxt;
         upd_addr  <= upd_addr_nxt;
         upd_take  <= upd_take_nxt;
         brn_cnt   <= brn_cnt_nxt;
         misp_cnt  <= misp_cnt_nxt;
      end
   end

   assign BRC_PC_LD     = pc_ld;
   assign BRC_PC_ADDR   = pc_addr;
   assign BRC_FLUSH     = (state == FLUSH);
   assign BRC_BUSY      = (state == FLUSH);
   assign BRC_UPD_VALID = upd_valid;
   assign BRC_UPD_ADDR  = upd_addr;
   assign BRC_UPD_TAKE  = upd_take;
   assign BRC_BRN_CNT   = brn_cnt;
   assign BRC_MISP_CNT  = misp_cnt;

endmodule
